lcd_ctrl: RTL

Memory-mapped LCD controller downstream of the LSU's LCD output register. Watches the 32-bit LCD register value and turns each software request into a correctly timed HD44780-style write cycle (setup, enable pulse, hold, execution wait). Removes software busy-wait loops and reports busy and overrun status for readback through the LSU input path.

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_req_fifo.sv | 54 +++++
 rtl/lcd_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_pkg                                                              |
// | Shared FSM states, LSU register bit positions and command decoding   |
// | for the HD44780-style LCD controller.                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN    = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  localparam int LCD_ON_BIT  = 31;
  localparam int LCD_TOG_BIT = 30;
  localparam int LCD_CLR_BIT = 29;
  localparam int LCD_RS_BIT  = 8;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_req_fifo                                                         |
// | Pending LCD request queue; exposes the entry after the head, since   |
// | the head is the transaction currently on the bus.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd_req_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int c_PTR_W = $clog2(DEPTH),
  localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_push_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_next_data,
  output logic [c_CNT_W-1:0] o_count
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != c_CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_next_data = r_mem[r_rd_ptr + c_PTR_W'(1)];
  assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_ctrl                                                             |
// | Turns LSU LCD register toggles into timed HD44780 write cycles.      |
// | LCD_FIFO_EN adds a request queue; otherwise busy requests are dropped.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_EXEC_CYC  = 2500,
  parameter int T_LONG_CYC  = 82000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int c_CNT_W = $clog2(T_LONG_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(T_SETUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_EN_LD    = c_CNT_W'(T_EN_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(T_HOLD_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_EXEC_LD  = c_CNT_W'(T_EXEC_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LONG_LD  = c_CNT_W'(T_LONG_CYC - 1);

  lcd_state_e         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_tog;
  logic               r_lcd_rs;
  logic [7:0]         r_lcd_data;
  logic               r_lcd_en;
  logic               r_lcd_on;
  logic               r_overrun;

  logic               w_req;
  logic               w_exit;
  logic               w_accept;
  logic               w_start;
  logic               w_drop;
  logic               w_pending;
  logic [8:0]         w_start_cmd;
  logic               w_unused;

  assign w_req    = i_io_lcd[LCD_TOG_BIT] != r_tog;
  assign w_exit   = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_accept = (r_state == ST_IDLE) || w_exit;

`ifdef LCD_FIFO_EN
  localparam int c_FIFO_CW = $clog2(FIFO_DEPTH + 1);

  logic [c_FIFO_CW-1:0] w_fifo_count;
  logic [8:0]           w_fifo_next;
  logic                 w_full;
  logic                 w_from_fifo;

  // The queue head is the transaction in flight; it is popped when its WAIT ends.
  assign w_full      = (w_fifo_count == c_FIFO_CW'(FIFO_DEPTH));
  assign w_from_fifo = w_exit && (w_fifo_count > c_FIFO_CW'(1));
  assign w_start     = w_from_fifo || (w_accept && w_req);
  assign w_start_cmd = w_from_fifo ? w_fifo_next : i_io_lcd[LCD_RS_BIT:0];
  assign w_drop      = w_req && w_full && !w_exit;
  assign w_pending   = (w_fifo_count != '0);

  lcd_req_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_req && !w_drop),
    .i_push_data (i_io_lcd[LCD_RS_BIT:0]),
    .i_pop       (w_exit),
    .o_next_data (w_fifo_next),
    .o_count     (w_fifo_count)
  );
`else
  assign w_start     = w_accept && w_req;
  assign w_start_cmd = i_io_lcd[LCD_RS_BIT:0];
  assign w_drop      = w_req && !w_accept;
  assign w_pending   = 1'b0;
`endif

  assign w_unused = ^{i_io_lcd[LCD_CLR_BIT-1:LCD_RS_BIT+1], (FIFO_DEPTH > 0)};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tog      <= 1'b0;
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= 8'd0;
      r_lcd_en   <= 1'b0;
      r_lcd_on   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tog    <= i_io_lcd[LCD_TOG_BIT];
      r_lcd_on <= i_io_lcd[LCD_ON_BIT];

      if (w_drop)                       r_overrun <= 1'b1;
      else if (i_io_lcd[LCD_CLR_BIT])   r_overrun <= 1'b0;

      if (w_start) begin
        r_state    <= ST_SETUP;
        r_cnt      <= c_SETUP_LD;
        r_lcd_rs   <= w_start_cmd[8];
        r_lcd_data <= w_start_cmd[7:0];
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end else begin
        case (r_state)
          ST_SETUP: begin
            r_state  <= ST_EN;
            r_cnt    <= c_EN_LD;
            r_lcd_en <= 1'b1;
          end
          ST_EN: begin
            r_state  <= ST_HOLD;
            r_cnt    <= c_HOLD_LD;
            r_lcd_en <= 1'b0;
          end
          ST_HOLD: begin
            r_state <= ST_WAIT;
            r_cnt   <= is_long_cmd(r_lcd_rs, r_lcd_data) ? c_LONG_LD : c_EXEC_LD;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_lcd_data = r_lcd_data;
  assign o_lcd_rs   = r_lcd_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_lcd_en;
  assign o_lcd_on   = r_lcd_on;
  assign o_busy     = (r_state != ST_IDLE) || w_pending;
  assign o_overrun  = r_overrun;

endmodule
`default_nettype wire
